// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    localparam int NREQ = 2;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b110
    } alu_op_t;

    typedef struct packed {
        logic negative;
        logic zero;
        logic carry;
        logic over_flow;
    } alu_flags_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the ALU arbiter.
interface alu_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][WIDTH-1:0] req_a;
    logic [NREQ-1:0][WIDTH-1:0] req_b;
    logic [NREQ-1:0][2:0]       req_cntrl;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic                       rsp_id;
    logic [WIDTH-1:0]           rsp_result;
    alu_flags_t                 rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_cntrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cntrl, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: add/sub through one adder, AND/OR logic ops.
// Zero always reflects the adder sum; carry/over_flow are masked for logic ops.
module ALU
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // cntrl[0] selects subtract as a + ~b + 1
    assign b_eff       = cntrl[0] ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cntrl[0]};

    always_comb begin
        result = sum;
        case (cntrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = sum;
        endcase
    end

    assign flags.negative  = result[31];
    assign flags.zero      = (sum == '0);
    assign flags.carry     = ~cntrl[2] & cout;
    assign flags.over_flow = ~cntrl[2] & ~(a[31] ^ b_eff[31]) & (sum[31] ^ a[31]);
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with a one-entry response register.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
`ifdef ALU_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state_reg;
    logic             last_grant_reg;
    logic             id_reg;
    logic [WIDTH-1:0] result_reg;
    alu_flags_t       flags_reg;

    logic             can_accept;
    logic             both_winner;
    logic [NREQ-1:0]  grant;
    logic             sel;
    logic             accept;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_cntrl;
    logic [WIDTH-1:0] alu_result;
    alu_flags_t       alu_flags;

    assign can_accept = (state_reg == EMPTY) || bus.rsp_ready;

    // On contention round-robin picks the requester not served last; fixed priority picks 0
    assign both_winner = RR_EN & ~last_grant_reg;

    always_comb begin
        grant = bus.req_valid;
        if (&bus.req_valid) begin
            grant = both_winner ? 2'b10 : 2'b01;
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = ~rst & can_accept & grant[gi];
        end
    endgenerate

    assign accept = |bus.req_ready;
    assign sel    = grant[1];

    assign alu_a     = bus.req_a[sel];
    assign alu_b     = bus.req_b[sel];
    assign alu_cntrl = bus.req_cntrl[sel];

    ALU #(.WIDTH(WIDTH)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .cntrl  (alu_cntrl),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= EMPTY;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            result_reg     <= '0;
            flags_reg      <= '0;
        end else if (accept) begin
            // A new accept may overwrite a response being consumed this same edge
            state_reg      <= FULL;
            last_grant_reg <= sel;
            id_reg         <= sel;
            result_reg     <= alu_result;
            flags_reg      <= alu_flags;
        end else if ((state_reg == FULL) && bus.rsp_ready) begin
            state_reg      <= EMPTY;
        end
    end

    assign bus.rsp_valid  = (state_reg == FULL);
    assign bus.rsp_id     = id_reg;
    assign bus.rsp_result = result_reg;
    assign bus.rsp_flags  = flags_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, reset/backpressure/arbitration
// sequences and randomized traffic against a queue-based reference model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } op_t;

    typedef struct {
        logic        id;
        op_t         o;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    op_t         q0[$];
    op_t         q1[$];
    int          acc_log[$];
    int          total = 0;
    int          bad   = 0;

    logic        m_valid;
    logic        m_id;
    logic [31:0] m_result;
    logic [3:0]  m_flags;
    logic        m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU written from the arithmetic meaning of each op
    function automatic void model_alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op,
                                      output logic [31:0] r, output logic [3:0] f);
        logic [32:0] s;
        logic [31:0] adder;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b001: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b100:  r = a & b;
            default: r = a | b;
        endcase
        adder = op[0] ? (a - b) : (a + b);
        f = {r[31], (adder == 32'd0), c, v};
    endfunction

    function automatic int pick(input logic [1:0] v, input logic last);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return (RR && !last) ? 1 : 0;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.a = $urandom;
        case ($urandom_range(0, 3))
            0:       o.b = o.a;
            1:       o.b = -o.a;
            default: o.b = $urandom;
        endcase
        case ($urandom_range(0, 3))
            0:       o.op = 3'b000;
            1:       o.op = 3'b001;
            2:       o.op = 3'b100;
            default: o.op = 3'b110;
        endcase
        return o;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_id     = 1'b0;
        m_result = '0;
        m_flags  = '0;
        m_last   = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    task automatic drive_inputs();
        bus.req_valid = {q1.size() != 0, q0.size() != 0};
        if (q0.size() != 0) begin
            bus.req_a[0] = q0[0].a; bus.req_b[0] = q0[0].b; bus.req_cntrl[0] = q0[0].op;
        end
        if (q1.size() != 0) begin
            bus.req_a[1] = q1[0].a; bus.req_b[1] = q1[0].b; bus.req_cntrl[1] = q1[0].op;
        end
    endtask

    // One clock: drive at negedge, check ready, update model at posedge, check response at negedge
    task automatic cycle(input logic rdy);
        int         w;
        logic [1:0] exp_rdy;
        op_t        o;
        bus.rsp_ready = rdy;
        drive_inputs();
        #1;
        w = (!m_valid || rdy) ? pick(bus.req_valid, m_last) : -1;
        exp_rdy = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
        chk("req_ready", bus.req_ready, exp_rdy);
        if (bus.req_ready[0] && bus.req_valid[0]) acc_log.push_back(0);
        else if (bus.req_ready[1] && bus.req_valid[1]) acc_log.push_back(1);
        @(posedge clk);
        if (w >= 0) begin
            o = (w == 0) ? q0.pop_front() : q1.pop_front();
            model_alu(o.a, o.b, o.op, m_result, m_flags);
            m_valid = 1'b1;
            m_id    = (w == 1);
            m_last  = (w == 1);
            $display("accept id=%0d a=%h b=%h op=%b -> %h flags=%b", w, o.a, o.b, o.op, m_result, m_flags);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        chk("rsp_valid", bus.rsp_valid, m_valid);
        if (m_valid) begin
            chk("rsp_id", bus.rsp_id, m_id);
            chk("rsp_result", bus.rsp_result, m_result);
            chk("rsp_flags", bus.rsp_flags, m_flags);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_valid) && n < 100) begin
            cycle(1'b1);
            n++;
        end
        chk("drain_timeout", (n >= 100), 1'b0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] s_res;
        logic [3:0]  s_flg;
        logic        s_id;

        vecs[0] = '{1'b0, '{32'd5,          32'd3,          3'b000}, 32'd8,          4'b0000};
        vecs[1] = '{1'b1, '{32'd3,          32'd5,          3'b001}, 32'hFFFF_FFFE,  4'b1000};
        vecs[2] = '{1'b1, '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  3'b001}, 32'h8000_0000,  4'b1001};
        vecs[3] = '{1'b0, '{32'hF0F0_F0F0,  32'h0FF0_0FF0,  3'b100}, 32'h00F0_00F0,  4'b0000};
        vecs[4] = '{1'b1, '{32'hF0F0_F0F0,  32'h0FF0_0FF0,  3'b110}, 32'hFFF0_FFF0,  4'b1000};
        vecs[5] = '{1'b0, '{32'd1,          32'hFFFF_FFFF,  3'b000}, 32'd0,          4'b0110};
        vecs[6] = '{1'b1, '{32'd1,          32'hFFFF_FFFF,  3'b100}, 32'd1,          4'b0100};
        vecs[7] = '{1'b0, '{32'h7FFF_FFFF,  32'd1,          3'b000}, 32'h8000_0000,  4'b1001};
        vecs[8] = '{1'b1, '{32'd5,          32'd5,          3'b001}, 32'd0,          4'b0110};

        bus.req_valid = 2'b11;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cntrl = '0;
        bus.rsp_ready = 1'b0;
        model_reset();

        // Reset state, with both requesters asking
        @(negedge clk);
        @(negedge clk);
        chk("reset_req_ready", bus.req_ready, 2'b00);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_rsp_id", bus.rsp_id, 1'b0);
        chk("reset_rsp_result", bus.rsp_result, 32'd0);
        chk("reset_rsp_flags", bus.rsp_flags, 4'd0);
        rst = 1'b0;

        // Directed vector table, one op at a time
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].id) q1.push_back(vecs[i].o);
            else            q0.push_back(vecs[i].o);
            cycle(1'b1);
            chk("vec_valid", bus.rsp_valid, 1'b1);
            chk("vec_id", bus.rsp_id, vecs[i].id);
            chk("vec_result", bus.rsp_result, vecs[i].r);
            chk("vec_flags", bus.rsp_flags, vecs[i].f);
            cycle(1'b1);
        end

        // Backpressure: both valid, consumer stalled for 4 cycles
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rnd_op());
            q1.push_back(rnd_op());
        end
        cycle(1'b0);
        s_res = bus.rsp_result;
        s_flg = bus.rsp_flags;
        s_id  = bus.rsp_id;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0);
            chk("bp_ready", bus.req_ready, 2'b00);
            chk("bp_hold_result", bus.rsp_result, s_res);
            chk("bp_hold_flags", bus.rsp_flags, s_flg);
            chk("bp_hold_id", bus.rsp_id, s_id);
        end
        drain();

        // Asynchronous reset while FULL, between clock edges
        q0.push_back(rnd_op());
        q0.push_back(rnd_op());
        q1.push_back(rnd_op());
        q1.push_back(rnd_op());
        cycle(1'b1);
        chk("pre_reset_full", bus.rsp_valid, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.rsp_valid, 1'b0);
        chk("async_rst_result", bus.rsp_result, 32'd0);
        chk("async_rst_flags", bus.rsp_flags, 4'd0);
        chk("async_rst_ready", bus.req_ready, 2'b00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Arbitration: both stream 6 ops with the consumer always ready
        acc_log.delete();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(rnd_op());
            q1.push_back(rnd_op());
        end
        drain();
        chk("arb_count", acc_log.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < acc_log.size())
                chk("arb_order", acc_log[i], RR ? (i % 2) : (i < 6 ? 0 : 1));
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 2 && $urandom_range(0, 2) != 0) q0.push_back(rnd_op());
            if (q1.size() < 2 && $urandom_range(0, 2) != 0) q1.push_back(rnd_op());
            cycle($urandom_range(0, 3) != 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `ALU` instance between two requesters, such as the execute stage and the address/branch-compare path, using valid/ready handshakes on both sides. Each accepted request is evaluated in the cycle it is accepted. The result and flags are registered and returned with the requester ID on a single response channel, at a sustained throughput of one operation per cycle.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width. Only 32 is supported, because ALU flag logic uses bit 31.

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, 2: per-requester request valid.
- `req_ready`, output, 2: per-requester accept. At most one bit is high.
- `req_a`, input, 2×WIDTH: operand A per requester.
- `req_b`, input, 2×WIDTH: operand B per requester.
- `req_cntrl`, input, 2×3: ALU control per requester.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: response consumer accept.
- `rsp_id`, output, 1: index of the requester that issued the response.
- `rsp_result`, output, WIDTH: registered ALU result.
- `rsp_flags`, output, 4: registered {negative, zero, carry, over_flow}.

## Operation
- One-entry output register (`rsp_*`) plus a grant pointer `last_grant`.
- Two states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- `can_accept` = EMPTY | (FULL & `rsp_ready`).
- Grant is combinational from `req_valid` and `last_grant`. `req_ready[i]` = `can_accept` & `grant[i]`.
- Accept (`req_valid[i]` & `req_ready[i]`) has these effects:
  - Muxes requester i's a/b/cntrl into the ALU.
  - Captures the ALU result, flags and id i into the output register.
  - Sets state FULL and sets `last_grant` to i.
- In FULL with `rsp_ready`=1 and no accept: state returns to EMPTY. Register contents hold but are don't-care.
- In FULL with `rsp_ready`=0: all `rsp_*` outputs hold stable and `req_ready` is 0.
- Simultaneous response handshake and new accept: the new result replaces the old one in the same edge and state stays FULL. There is no bubble.
- Both requesters valid: arbitration follows the Configuration section.
- A requester must hold a/b/cntrl stable while `req_valid` is high and it has not been accepted. `req_valid` must not be dropped before acceptance.
- Control encodings, passed unchanged to the ALU:
  - ADD=3'b000, SUB=3'b001, AND=3'b100, OR=3'b110.
  - Other encodings get whatever the ALU produces. No checking is done.
- Flags are the ALU outputs unmodified. Zero reflects the adder sum, including for AND/OR.

## Timing
- Reset values:
  - State EMPTY, `rsp_valid`=0.
  - `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0.
  - `last_grant`=1, so requester 0 is favoured first.
- `req_ready` is forced to 0 while `rst` is high.
- Latency: the response is visible the cycle after acceptance, which is 1 clock.
- Throughput: 1 op/cycle while `rsp_ready` is held high.
- Reset asserted mid-operation discards any pending response immediately (asynchronous). No request is accepted until the first edge after `rst` deasserts.
- No combinational path runs from `rsp_ready` to `rsp_valid`. A path exists from `rsp_ready` to `req_ready`; this is intentional.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - With both requesters valid, the requester not equal to `last_grant` wins.
  - A single valid requester always wins.
- `ALU_ARB_RR_EN` undefined: fixed priority, where requester 0 always wins.
  - `last_grant` is still maintained, but unused for arbitration.
  - Requester 1 can starve. This is permitted in this mode.

## Structure
- Shared package `alu_arb_pkg` holds:
  - `alu_op_t` enum (ADD/SUB/AND/OR with the encodings above).
  - `alu_flags_t` packed struct {negative, zero, carry, over_flow}.
  - `NREQ`=2 constant.
- One sub-module: the existing `ALU` (WIDTH=32), instantiated once. Arbiter and mux logic stay inline.

## Test plan
- Reset: assert `rst` mid-stream with FULL state.
  - Expect `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0 and `req_ready`=0 immediately.
  - First grant after release goes to requester 0.
- Single ADD: requester 0 sends a=5, b=3, cntrl=000.
  - Next cycle: `rsp_valid`=1, `rsp_id`=0, `rsp_result`=8, flags=0000.
- SUB flags: requester 1 sends a=3, b=5, cntrl=001.
  - Expect result=32'hFFFF_FFFE, negative=1, zero=0, carry=0.
  - Then a=32'h7FFF_FFFF, b=32'hFFFF_FFFF, SUB: expect over_flow=1.
- Backpressure: hold `rsp_ready`=0 for 4 cycles with both requesters valid.
  - `rsp_*` stay stable and `req_ready`=00.
  - Releasing `rsp_ready` gives a same-cycle new accept and back-to-back responses.
- Arbitration: both requesters stream 6 ops with `rsp_ready`=1.
  - With `ALU_ARB_RR_EN`: ids 0,1,0,1,0,1.
  - Without it: ids 0,0,0,0,0,0, then requester 1's ops follow.
- AND/OR: a=32'hF0F0_F0F0, b=32'h0FF0_0FF0.
  - AND gives 32'h00F0_00F0; OR gives 32'hFFF0_FFF0.
  - Zero flag equals zero(a+b) or zero(a−b) per cntrl[0].
